// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Processor-side initiator for the unified instruction/data memory port.
// Instruction fetches and load/store requests from the multi-cycle core are
// sequenced onto the single port (mem_A, mem_WD, mem_WE, mem_Adrsrc -> mem_RD).
// Byte and half stores are done by read-modify-write. Loads are sign- or
// zero-extended. Every accepted request produces exactly one response.
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses return rsp_err=1, no memory access
//   undefined : misaligned addresses are aligned down and the access proceeds
// Out-of-range data accesses (word index >= DMEM_DEPTH) always return rsp_err=1.
//
// Ports
//   CLK            clock, rising edge
//   RST            synchronous reset, active low
//   fetch_req      instruction fetch request
//   fetch_addr     fetch byte address
//   ls_req         load/store request (wins over fetch_req)
//   ls_we          1 = store, 0 = load
//   ls_size        0 byte, 1 half, 2/3 word
//   ls_unsigned    zero-extend loads
//   ls_addr        data byte address
//   ls_wdata       store data, right-aligned
//   req_ready      high only in IDLE; accept = req && req_ready
//   rsp_valid      one-cycle response strobe
//   rsp_is_fetch   response belongs to a fetch
//   rsp_data       instruction / extended load data, 0 for stores and errors
//   rsp_err        misaligned (trap build) or out-of-range access
//   mem_A          fetch: byte address, data: word index
//   mem_WD         memory write data
//   mem_WE         memory write enable
//   mem_Adrsrc     0 = instruction ROM, 1 = data RAM
//   mem_RD         combinational memory read data
//
// Handshake: a request is taken on a rising edge where (ls_req || fetch_req)
// and req_ready are both high; the response is signalled by rsp_valid for one
// cycle and rsp_data/rsp_err/rsp_is_fetch hold their values until the next
// response.
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int DMEM_DEPTH = 50,
  parameter int XLEN       = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            fetch_req,
  input  logic [XLEN-1:0] fetch_addr,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [1:0]      ls_size,
  input  logic            ls_unsigned,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  output logic            req_ready,
  output logic            rsp_valid,
  output logic            rsp_is_fetch,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err,
  output logic [XLEN-1:0] mem_A,
  output logic [XLEN-1:0] mem_WD,
  output logic            mem_WE,
  output logic            mem_Adrsrc,
  input  logic [XLEN-1:0] mem_RD
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_STORE  = 3'd3;
  localparam logic [2:0] S_RMW_RD = 3'd4;
  localparam logic [2:0] S_RMW_WR = 3'd5;
  localparam logic [2:0] S_RESP   = 3'd6;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;

  localparam logic [XLEN-1:0] DEPTH_W = XLEN'(DMEM_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;       // fetch address or aligned data byte address
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rmw_q, rmw_d;         // word captured in RMW_RD
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_fetch_q, rsp_fetch_d;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic            ls_is_byte, ls_is_half, ls_is_word;
  logic [XLEN-1:0] ls_word_idx;
  logic            ls_oor, ls_mis, ls_err;
  logic [XLEN-1:0] ls_addr_al;

  assign ls_is_byte  = (ls_size == SZ_BYTE);
  assign ls_is_half  = (ls_size == SZ_HALF);
  assign ls_is_word  = !ls_is_byte && !ls_is_half;
  assign ls_word_idx = {2'b00, ls_addr[XLEN-1:2]};
  assign ls_oor      = (ls_word_idx >= DEPTH_W);

  // Aligning down is harmless in the trap build: any address it would change
  // is rejected before a memory cycle is issued.
  always_comb begin
    ls_addr_al = ls_addr;
    if (ls_is_half) ls_addr_al[0]   = 1'b0;
    if (ls_is_word) ls_addr_al[1:0] = 2'b00;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign ls_mis = (ls_is_half && ls_addr[0]) ||
                  (ls_is_word && (ls_addr[1:0] != 2'b00));
`else
  assign ls_mis = 1'b0;
`endif

  assign ls_err = ls_oor || ls_mis;

  // ---------------------------------------------------------------------------
  // Lane helpers (little-endian; byte lane = addr[1:0], half lane = addr[1])
  // ---------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [1:0]      off,
                                                  input logic [1:0]      size,
                                                  input logic            uns);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    if (size == SZ_BYTE) begin
      r = uns ? {{(XLEN-8){1'b0}}, b} : {{(XLEN-8){b[7]}}, b};
    end else if (size == SZ_HALF) begin
      r = uns ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
    end else begin
      r = word;
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] merge_lane(input logic [XLEN-1:0] word,
                                                 input logic [XLEN-1:0] wd,
                                                 input logic [1:0]      off,
                                                 input logic [1:0]      size);
    logic [XLEN-1:0] r;
    r = word;
    if (size == SZ_BYTE) begin
      case (off)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      if (off[1]) r[31:16] = wd[15:0];
      else        r[15:0]  = wd[15:0];
    end else begin
      r = wd;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    rmw_d       = rmw_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_fetch_d = rsp_fetch_q;

    case (state_q)
      S_IDLE: begin
        if (ls_req) begin
          addr_d  = ls_addr_al;
          size_d  = ls_size;
          uns_d   = ls_unsigned;
          wdata_d = ls_wdata;
          if (ls_err) begin
            // Error responses skip the memory entirely.
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            rsp_fetch_d = 1'b0;
            state_d     = S_RESP;
          end else if (!ls_we) begin
            state_d = S_LOAD;
          end else if (ls_is_word) begin
            state_d = S_STORE;
          end else begin
            state_d = S_RMW_RD;
          end
        end else if (fetch_req) begin
          addr_d  = fetch_addr;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        rsp_data_d  = mem_RD;
        rsp_err_d   = 1'b0;
        rsp_fetch_d = 1'b1;
        state_d     = S_RESP;
      end
      S_LOAD: begin
        rsp_data_d  = load_extend(mem_RD, addr_q[1:0], size_q, uns_q);
        rsp_err_d   = 1'b0;
        rsp_fetch_d = 1'b0;
        state_d     = S_RESP;
      end
      S_STORE: begin
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        rsp_fetch_d = 1'b0;
        state_d     = S_RESP;
      end
      S_RMW_RD: begin
        rmw_d   = mem_RD;
        state_d = S_RMW_WR;
      end
      S_RMW_WR: begin
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        rsp_fetch_d = 1'b0;
        state_d     = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      rmw_q       <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_fetch_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      rmw_q       <= rmw_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_fetch_q <= rsp_fetch_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Memory signals are decoded purely from the state, so they are 0
  // outside the memory states and WE can never coincide with a read capture.
  // ---------------------------------------------------------------------------
  assign req_ready    = (state_q == S_IDLE);
  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_is_fetch = rsp_fetch_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;

  always_comb begin
    mem_A      = '0;
    mem_WD     = '0;
    mem_WE     = 1'b0;
    mem_Adrsrc = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_A = addr_q;
      end
      S_LOAD, S_RMW_RD: begin
        mem_Adrsrc = 1'b1;
        mem_A      = {2'b00, addr_q[XLEN-1:2]};
      end
      S_STORE: begin
        mem_Adrsrc = 1'b1;
        mem_A      = {2'b00, addr_q[XLEN-1:2]};
        mem_WE     = 1'b1;
        mem_WD     = wdata_q;
      end
      S_RMW_WR: begin
        mem_Adrsrc = 1'b1;
        mem_A      = {2'b00, addr_q[XLEN-1:2]};
        mem_WE     = 1'b1;
        mem_WD     = merge_lane(rmw_q, wdata_q, addr_q[1:0], size_q);
      end
      default: begin
        mem_A = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Bench for mem_access_ctrl: behavioural ROM/RAM on the memory port, a driver
// task issuing requests, a scoreboard queue of expected responses (value and
// arrival cycle) and a final report.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam int DEPTH = 50;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  int          cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  logic        fetch_req, ls_req, ls_we, ls_unsigned;
  logic [31:0] fetch_addr, ls_addr, ls_wdata;
  logic [1:0]  ls_size;
  logic        req_ready, rsp_valid, rsp_is_fetch, rsp_err;
  logic [31:0] rsp_data, mem_A, mem_WD, mem_RD;
  logic        mem_WE, mem_Adrsrc;

  mem_access_ctrl #(.DMEM_DEPTH(DEPTH), .XLEN(32)) dut (
    .CLK(CLK), .RST(RST),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_is_fetch(rsp_is_fetch),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_Adrsrc(mem_Adrsrc),
    .mem_RD(mem_RD)
  );

  // ---------------------------------------------------------------------------
  // Memory models: ROM is a fixed function of the word address, RAM is an array
  // written by the DUT. exp_ram is the bench's own view of what RAM should hold.
  // ---------------------------------------------------------------------------
  logic [31:0] ram     [0:63];
  logic [31:0] exp_ram [0:63];

  function automatic logic [31:0] rom_val(input logic [31:0] a);
    return 32'hA500_0000 + (a >> 2) * 32'h11;
  endfunction

  assign mem_RD = mem_Adrsrc ? ((mem_A < DEPTH) ? ram[mem_A[5:0]] : 32'h0)
                             : rom_val(mem_A);

  always @(posedge CLK)
    if (mem_WE && mem_Adrsrc && (mem_A < DEPTH)) ram[mem_A[5:0]] <= mem_WD;

  // ---------------------------------------------------------------------------
  // Scoreboard: {arrival cycle[15:0], is_fetch, err, data[31:0]}
  // ---------------------------------------------------------------------------
  logic [49:0] exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          we_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (mem_WE) we_cnt++;
    if (RST && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        logic [49:0] e;
        e = exp_q.pop_front();
        check_eq("rsp_data",     64'(rsp_data),     64'(e[31:0]));
        check_eq("rsp_err",      64'(rsp_err),      64'(e[32]));
        check_eq("rsp_is_fetch", 64'(rsp_is_fetch), 64'(e[33]));
        check_eq("rsp_cycle",    64'(cyc[15:0]),    64'(e[49:34]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model of load extension and sub-word merge (shift/mask form)
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic u);
    logic [31:0] w, v;
    int          sh;
    w = exp_ram[a[7:2]];
    if (sz == 2'd0) begin
      sh = int'(a[1:0]) * 8;
      v  = (w >> sh) & 32'hFF;
      if (!u && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      sh = int'(a[1]) * 16;
      v  = (w >> sh) & 32'hFFFF;
      if (!u && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_merge(input logic [31:0] w, input logic [31:0] a,
                                            input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] mask;
    int          sh;
    sh   = (sz == 2'd0) ? int'(a[1:0]) * 8 : int'(a[1]) * 16;
    mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: called and returns on a negedge. Holds the request until accepted,
  // pushes the expected response, then drops the request. On return the bench
  // sits in cycle N+1 relative to acceptance cycle N.
  // ---------------------------------------------------------------------------
  task automatic issue(input bit f, input bit we, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] wd, input bit want);
    logic [31:0] d;
    bit          err, mis;
    int          lat, n;
    d = 32'h0; err = 1'b0; lat = 2;
    if (f) begin
      d = rom_val(a);
    end else begin
      mis = TRAP_EN && (((sz == 2'd1) && a[0]) || ((sz >= 2'd2) && (a[1:0] != 2'b00)));
      err = ((a >> 2) >= DEPTH) || mis;
      if (err) begin
        lat = 1;
      end else if (!we) begin
        d = exp_load(a, sz, u);
      end else begin
        lat = (sz >= 2'd2) ? 2 : 3;
        if (want)
          exp_ram[a[7:2]] = (sz >= 2'd2) ? wd : exp_merge(exp_ram[a[7:2]], a, sz, wd);
      end
    end
    fetch_req   = f;
    fetch_addr  = a;
    ls_req      = !f;
    ls_we       = we;
    ls_size     = sz;
    ls_unsigned = u;
    ls_addr     = a;
    ls_wdata    = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready) check_eq("accept_timeout", 64'd0, 64'd1);
    if (want) exp_q.push_back({16'(cyc + lat), f, err, d});
    @(negedge CLK);
    fetch_req = 1'b0;
    ls_req    = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if (req_ready && exp_q.size() == 0) ok = 1'b1;
    end
    check_eq("idle_reached", 64'(ok), 64'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int          w0, n0;
    logic [31:0] ra;
    logic [1:0]  rs;

    for (int i = 0; i < 64; i++) begin
      ram[i]     = 32'h0;
      exp_ram[i] = 32'h0;
    end
    fetch_req = 0; ls_req = 0; ls_we = 0; ls_unsigned = 0; ls_size = 0;
    fetch_addr = 0; ls_addr = 0; ls_wdata = 0;

    // Reset state
    repeat (3) @(negedge CLK);
    check_eq("rst_req_ready",    64'(req_ready),    64'd1);
    check_eq("rst_rsp_valid",    64'(rsp_valid),    64'd0);
    check_eq("rst_rsp_is_fetch", 64'(rsp_is_fetch), 64'd0);
    check_eq("rst_rsp_err",      64'(rsp_err),      64'd0);
    check_eq("rst_rsp_data",     64'(rsp_data),     64'd0);
    check_eq("rst_mem_bus",      {mem_A, mem_WD}, 64'd0);
    check_eq("rst_mem_ctl",      64'({mem_WE, mem_Adrsrc}), 64'd0);
    RST = 1'b1;
    @(negedge CLK);

    // Fetch 0x8
    issue(1, 0, 2'd2, 0, 32'h8, 32'h0, 1);
    check_eq("fetch_mem_A",   64'(mem_A),      64'h8);
    check_eq("fetch_adrsrc",  64'(mem_Adrsrc), 64'd0);
    check_eq("fetch_we",      64'(mem_WE),     64'd0);
    wait_idle();

    // Word store then word load
    w0 = we_cnt;
    issue(0, 1, 2'd2, 0, 32'h80, 32'hDEAD_BEEF, 1);
    check_eq("sw_mem_A",   64'(mem_A),      64'h20);
    check_eq("sw_we",      64'(mem_WE),     64'd1);
    check_eq("sw_wd",      64'(mem_WD),     64'hDEAD_BEEF);
    check_eq("sw_adrsrc",  64'(mem_Adrsrc), 64'd1);
    wait_idle();
    check_eq("sw_we_pulses", 64'(we_cnt - w0), 64'd1);
    issue(0, 0, 2'd2, 0, 32'h80, 32'h0, 1);
    wait_idle();

    // Byte store by read-modify-write
    issue(0, 1, 2'd2, 0, 32'h80, 32'h1122_3344, 1);
    wait_idle();
    issue(0, 1, 2'd0, 0, 32'h81, 32'h0000_005A, 1);
    check_eq("rmw_rd_we",     64'(mem_WE),     64'd0);
    check_eq("rmw_rd_adrsrc", 64'(mem_Adrsrc), 64'd1);
    check_eq("rmw_rd_mem_A",  64'(mem_A),      64'h20);
    @(negedge CLK);
    check_eq("rmw_wr_we",     64'(mem_WE),     64'd1);
    check_eq("rmw_wr_wd",     64'(mem_WD),     64'h1122_5A44);
    wait_idle();
    check_eq("rmw_ram", 64'(ram[32]), 64'(exp_ram[32]));

    // Signed / unsigned byte load
    issue(0, 1, 2'd2, 0, 32'h80, 32'h0000_80FF, 1);
    issue(0, 0, 2'd0, 0, 32'h81, 32'h0, 1);
    issue(0, 0, 2'd0, 1, 32'h81, 32'h0, 1);
    wait_idle();

    // Simultaneous fetch and load: load first, fetch right after RESP
    fetch_req = 1; fetch_addr = 32'h10;
    ls_req = 1; ls_we = 0; ls_size = 2'd2; ls_unsigned = 0; ls_addr = 32'h80;
    n0 = cyc;
    exp_q.push_back({16'(n0 + 2), 1'b0, 1'b0, exp_load(32'h80, 2'd2, 1'b0)});
    exp_q.push_back({16'(n0 + 5), 1'b1, 1'b0, rom_val(32'h10)});
    @(negedge CLK);
    ls_req = 0;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge CLK);
    check_eq("fetch_accept_cyc", 64'(cyc - n0), 64'd3);
    @(negedge CLK);
    fetch_req = 0;
    wait_idle();

    // Misaligned half load at 0x83
    issue(0, 1, 2'd2, 0, 32'h80, 32'hC3D2_80FF, 1);
    wait_idle();
    issue(0, 0, 2'd1, 0, 32'h83, 32'h0, 1);
    check_eq("mis_adrsrc", 64'(mem_Adrsrc), TRAP_EN ? 64'd0 : 64'd1);
    wait_idle();
    issue(0, 0, 2'd2, 0, 32'h86, 32'h0, 1);
    wait_idle();

    // Half store, unsigned half load
    issue(0, 1, 2'd1, 0, 32'h82, 32'h0000_ABCD, 1);
    issue(0, 0, 2'd1, 1, 32'h82, 32'h0, 1);
    wait_idle();

    // Range boundary: index 49 valid, index 50 out of range
    w0 = we_cnt;
    issue(0, 1, 2'd2, 0, 32'd196, 32'h0BAD_F00D, 1);
    issue(0, 0, 2'd2, 0, 32'd196, 32'h0, 1);
    wait_idle();
    check_eq("edge_we_pulses", 64'(we_cnt - w0), 64'd1);
    w0 = we_cnt;
    issue(0, 1, 2'd2, 0, 32'd200, 32'h1234_5678, 1);
    check_eq("oor_adrsrc", 64'(mem_Adrsrc), 64'd0);
    issue(0, 0, 2'd0, 0, 32'd203, 32'h0, 1);
    wait_idle();
    check_eq("oor_no_we", 64'(we_cnt - w0), 64'd0);

    // Random mix
    for (int i = 0; i < 30; i++) begin
      ra = 32'($urandom_range(0, 207));
      rs = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       issue(1, 0, 2'd2, 0, 32'($urandom_range(0, 63)) * 4, 32'h0, 1);
        1:       issue(0, 1, rs, 0, ra, $urandom, 1);
        default: issue(0, 0, rs, 1'($urandom_range(0, 1)), ra, 32'h0, 1);
      endcase
    end
    wait_idle();
    for (int i = 0; i < DEPTH; i++) check_eq($sformatf("ram_%0d", i), 64'(ram[i]), 64'(exp_ram[i]));

    // Reset during RMW_RD: no write, no response
    w0 = we_cnt;
    issue(0, 1, 2'd0, 0, 32'h90, 32'h0000_00EE, 0);
    RST = 1'b0;
    @(negedge CLK);
    check_eq("rst_mid_we",        64'(mem_WE),    64'd0);
    check_eq("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_mid_ready",     64'(req_ready), 64'd1);
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    check_eq("rst_mid_no_we", 64'(we_cnt - w0), 64'd0);
    check_eq("rst_mid_ram",   64'(ram[36]), 64'(exp_ram[36]));

    // Machine still works after the abort
    issue(1, 0, 2'd2, 0, 32'h40, 32'h0, 1);
    wait_idle();
    check_eq("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
